// File: rtl/wb_shared_ram_slave_pkg.sv
// Shared definitions for the multi-master Wishbone RAM slave.
package wb_shared_ram_slave_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEFAULT_NUM_M = 4;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    // One master's request as seen by the arbiter
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_ram_1rw.sv
// Single-port synchronous RAM, one-cycle read latency, write-first, no reset.
module wb_ram_1rw
    import wb_shared_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wb_shared_ram_slave.sv
// Round-robin Wishbone slave sharing one 32-bit RAM between NUM_M data masters.
module wb_shared_ram_slave
    import wb_shared_ram_slave_pkg::*;
#(
    parameter int unsigned NUM_M  = DEFAULT_NUM_M,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        cyc_i,
    input  logic [NUM_M-1:0]        we_i,
    input  logic [NUM_M*DATA_W-1:0] adr_i,
    input  logic [NUM_M*DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0]       dat_o,
    output logic [NUM_M-1:0]        ack_o,
    output logic                    busy_o
);

    localparam int unsigned GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, last_q, winner, rr_idx;
    logic              found;
    logic [NUM_M-1:0]  blocked_q, eligible;
    wb_req_t           sel_req;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_adr_bits;

    assign eligible = cyc_i & ~blocked_q;

    // Round-robin search starting just after the last grant
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        rr_idx = '0;
        for (int k = 1; k <= int'(NUM_M); k++) begin
            rr_idx = GW'((int'(last_q) + k) % int'(NUM_M));
            if (!found && eligible[rr_idx]) begin
                found  = 1'b1;
                winner = rr_idx;
            end
        end
    end

    always_comb begin
        sel_req = '0;
        for (int m = 0; m < int'(NUM_M); m++) begin
            if (winner == GW'(m)) begin
                sel_req.we  = we_i[m];
                sel_req.adr = adr_i[DATA_W*m +: DATA_W];
                sel_req.dat = dat_i[DATA_W*m +: DATA_W];
            end
        end
    end

    // Byte-lane bits and bits above the RAM depth are don't-care
    assign unused_adr_bits = ^{sel_req.adr[DATA_W-1:ADDR_W+2], sel_req.adr[1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = ACCESS;
            ACCESS:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= GW'(NUM_M - 1);
            grant_q   <= '0;
            blocked_q <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= ZERO_WORD;
        end else begin
            state_q   <= state_d;
            blocked_q <= '0;
            if (state_q == IDLE && found) begin
                grant_q <= winner;
                last_q  <= winner;
                we_q    <= sel_req.we;
                adr_q   <= sel_req.adr[ADDR_W+1:2];
                dat_q   <= sel_req.dat;
            end
            // Master just served sits out the following IDLE cycle
            if (state_q == ACK) begin
                blocked_q <= NUM_M'(1) << grant_q;
            end
        end
    end

    wb_ram_1rw #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (state_q == ACCESS),
        .we    (we_q),
        .addr  (adr_q),
        .wdata (dat_q),
        .rdata (ram_rdata)
    );

    // Ack only while the granted master still holds its cycle
    always_comb begin
        ack_o = '0;
        dat_o = ZERO_WORD;
        if (state_q == ACK && cyc_i[grant_q]) begin
            ack_o[grant_q] = 1'b1;
            dat_o          = ram_rdata;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_wb_shared_ram_slave.sv
// Bench for wb_shared_ram_slave: directed scenarios plus random traffic against a timing model.
module tb_wb_shared_ram_slave;

    localparam int NUM_M  = 4;
    localparam int ADDR_W = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_M-1:0]    cyc_i, we_i;
    logic [NUM_M*32-1:0] adr_i, dat_i;
    logic [31:0]         dat_o;
    logic [NUM_M-1:0]    ack_o;
    logic                busy_o;

    always #5 clk = ~clk;

    wb_shared_ram_slave #(.NUM_M(NUM_M), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .cyc_i(cyc_i), .we_i(we_i), .adr_i(adr_i),
        .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .busy_o(busy_o)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: transfers occupy 3 cycles, ack lands 2 cycles after the grant edge
    int          cyc_t, free_at, ack_at, grant, last_grant;
    logic [31:0] exp_dat;
    bit          exp_known;
    logic [31:0] mem [int];

    bit          pend [NUM_M];
    bit          we_m [NUM_M];
    logic [31:0] adr_m [NUM_M];
    logic [31:0] dat_m [NUM_M];
    bit          done [NUM_M];
    bit          abort_req [NUM_M];
    bit          rand_mode;

    int          obs_who [$];
    int          obs_when [$];
    logic [31:0] obs_dat [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic req(int m, bit we, logic [31:0] adr, logic [31:0] dat);
        pend[m] = 1'b1; we_m[m] = we; adr_m[m] = adr; dat_m[m] = dat;
    endtask

    task automatic model_edge();
        int prev = cyc_t;
        int pick = -1;
        logic [NUM_M-1:0] elig = cyc_i;
        if (prev == ack_at + 1) elig[grant] = 1'b0;
        if (prev >= free_at && elig != '0) begin
            for (int k = 1; k <= NUM_M; k++) begin
                int idx = (last_grant + k) % NUM_M;
                if (elig[idx]) begin pick = idx; break; end
            end
            begin
                int wa = int'((adr_m[pick] >> 2) & ((32'd1 << ADDR_W) - 1));
                grant = pick; last_grant = pick;
                ack_at = prev + 2; free_at = prev + 3;
                if (we_m[pick]) begin
                    mem[wa] = dat_m[pick]; exp_dat = dat_m[pick]; exp_known = 1'b1;
                end else begin
                    exp_known = mem.exists(wa);
                    exp_dat = exp_known ? mem[wa] : 32'h0;
                end
            end
        end
        cyc_t++;
    endtask

    task automatic drive();
        for (int m = 0; m < NUM_M; m++) begin
            if (done[m] || abort_req[m]) begin
                pend[m] = 1'b0; done[m] = 1'b0; abort_req[m] = 1'b0;
            end
            if (rand_mode && !pend[m] && $urandom_range(2) == 0) begin
                logic [31:0] a = ($urandom << (ADDR_W + 2)) | (32'($urandom_range(7)) << 2)
                                 | 32'($urandom_range(3));
                req(m, 1'($urandom_range(1)), a, $urandom);
            end
            cyc_i[m] = pend[m];
            we_i[m]  = we_m[m];
            adr_i[32*m +: 32] = adr_m[m];
            dat_i[32*m +: 32] = dat_m[m];
        end
    endtask

    task automatic check_outputs();
        logic [NUM_M-1:0] exp_ack = '0;
        logic [31:0] ed = 32'h0;
        if (cyc_t == ack_at && cyc_i[grant]) begin
            exp_ack[grant] = 1'b1; ed = exp_dat; done[grant] = 1'b1;
        end
        for (int j = 0; j < NUM_M; j++)
            if (ack_o[j]) begin
                obs_who.push_back(j); obs_when.push_back(cyc_t); obs_dat.push_back(dat_o);
            end
        chk("ack_o", 32'(ack_o), 32'(exp_ack));
        chk("busy_o", 32'(busy_o), 32'(cyc_t >= free_at - 2 && cyc_t < free_at));
        if (exp_ack == '0 || exp_known) chk("dat_o", dat_o, ed);
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        model_edge();
        drive();
        #1;
        check_outputs();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic xfer(int m, bit we, logic [31:0] adr, logic [31:0] dat, string tag,
                        output logic [31:0] rd, output int lat);
        int n0 = obs_who.size();
        int t0;
        bit got = 1'b0;
        rd = 32'h0; lat = -1;
        req(m, we, adr, dat);
        cycle();
        t0 = cyc_t;
        for (int i = 0; i < 12 && !got; i++) begin
            cycle();
            for (int j = n0; j < obs_who.size(); j++)
                if (obs_who[j] == m) begin got = 1'b1; lat = obs_when[j] - t0; rd = obs_dat[j]; end
        end
        chk({tag, "_acked"}, 32'(got), 32'd1);
        cycle();
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        for (int m = 0; m < NUM_M; m++) begin
            pend[m] = 1'b0; done[m] = 1'b0; abort_req[m] = 1'b0;
        end
        cyc_i = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_grant = NUM_M - 1; free_at = cyc_t; ack_at = -100;
    endtask

    initial begin
        logic [31:0] rd;
        int lat, n0;
        bit seen1;

        rst = 1'b1; cyc_i = '0; we_i = '0; adr_i = '0; dat_i = '0;
        rand_mode = 1'b0;
        for (int m = 0; m < NUM_M; m++) begin
            pend[m] = 0; we_m[m] = 0; adr_m[m] = 0; dat_m[m] = 0; done[m] = 0; abort_req[m] = 0;
        end
        cyc_t = 0; free_at = 0; ack_at = -100; grant = 0; last_grant = NUM_M - 1;
        exp_dat = 0; exp_known = 0;
        #3;
        chk("init_ack", 32'(ack_o), 32'h0);
        chk("init_dat", dat_o, 32'h0);
        chk("init_busy", 32'(busy_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run(2);

        // Single write then read with fixed latency
        xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr0", rd, lat);
        chk("wr0_lat", 32'(lat), 32'd2);
        chk("wr0_dat", rd, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h0000_0010, 32'h0, "rd0", rd, lat);
        chk("rd0_lat", 32'(lat), 32'd2);
        chk("rd0_dat", rd, 32'hDEAD_BEEF);

        // All four masters from reset: served 0,1,2,3 every 3 cycles
        do_reset();
        n0 = obs_who.size();
        for (int m = 0; m < NUM_M; m++) req(m, 1'b0, 32'h0000_0010, 32'h0);
        run(15);
        chk("cont_count", 32'(obs_who.size() - n0), 32'd4);
        if (obs_who.size() >= n0 + 4)
            for (int i = 0; i < 4; i++) begin
                chk("cont_order", 32'(obs_who[n0+i]), 32'(i));
                if (i > 0) chk("cont_spacing", 32'(obs_when[n0+i] - obs_when[n0+i-1]), 32'd3);
            end

        // Last grant was master 3, so master 0 wins the tie
        n0 = obs_who.size();
        req(3, 1'b0, 32'h0000_0010, 32'h0);
        req(0, 1'b0, 32'h0000_0010, 32'h0);
        run(10);
        chk("wrap_count", 32'(obs_who.size() - n0), 32'd2);
        if (obs_who.size() >= n0 + 2) begin
            chk("wrap_first", 32'(obs_who[n0]), 32'd0);
            chk("wrap_second", 32'(obs_who[n0+1]), 32'd3);
        end

        // Master 1 drops cyc during ACCESS: no ack, write still lands
        n0 = obs_who.size();
        req(1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        cycle();
        abort_req[1] = 1'b1;
        run(4);
        seen1 = 1'b0;
        for (int j = n0; j < obs_who.size(); j++) if (obs_who[j] == 1) seen1 = 1'b1;
        chk("abort_noack", 32'(seen1), 32'd0);
        xfer(2, 1'b0, 32'h0000_0020, 32'h0, "abort_rb", rd, lat);
        chk("abort_rb_dat", rd, 32'h1234_5678);

        // Upper address bits alias onto the same word
        xfer(2, 1'b1, 32'h0001_4008, 32'hA5A5_A5A5, "alias_wr", rd, lat);
        xfer(0, 1'b0, 32'h0000_0008, 32'h0, "alias_rd", rd, lat);
        chk("alias_dat", rd, 32'hA5A5_A5A5);

        // Reset in the middle of an ACK cycle
        req(2, 1'b0, 32'h0000_0008, 32'h0);
        run(3);
        chk("mid_ack_pre", 32'(ack_o), 32'h4);
        do_reset();
        n0 = obs_who.size();
        req(3, 1'b0, 32'h0000_0008, 32'h0);
        req(0, 1'b0, 32'h0000_0010, 32'h0);
        run(8);
        chk("post_rst_count", 32'(obs_who.size() - n0), 32'd2);
        if (obs_who.size() > n0) chk("post_rst_first", 32'(obs_who[n0]), 32'd0);

        // Random traffic from all masters over a small aliased address pool
        rand_mode = 1'b1;
        run(400);
        rand_mode = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bit any = 1'b0;
            for (int m = 0; m < NUM_M; m++) any |= pend[m];
            if (!any) break;
            cycle();
        end
        begin
            bit any = 1'b0;
            for (int m = 0; m < NUM_M; m++) any |= pend[m];
            chk("drain_done", 32'(any), 32'd0);
        end
        run(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
